// File: rtl/digtal_tx_frame.sv
// Byte FIFO feeding an 8N1 async serialiser (LSB first, idle-high line).
// Optional even-parity bit between D7 and STOP when DIGTAL_TX_PARITY_EN is defined.
module digtal_tx_frame #(
  parameter int CLOCK_Frequency = 29491200,
  parameter int BAUD_Digtal     = 921600,
  parameter int FIFO_Depth      = 16,
  parameter int Idle_Gap        = 0
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic [7:0]                    Tx_Data,
  input  logic                          Tx_Valid,
  output logic                          Tx_Ready,
  output logic                          Tx,
  output logic                          Busy,
  output logic [$clog2(FIFO_Depth):0]   FIFO_Level
);

  localparam int BIT_CYCLES = CLOCK_Frequency / BAUD_Digtal;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int PTR_W      = $clog2(FIFO_Depth);
  localparam int LVL_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [3:0]       GAP_LAST = 4'(Idle_Gap - 1);

`ifdef DIGTAL_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;
`endif

  logic [7:0]       r_mem [FIFO_Depth];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [3:0]       r_gap;
  logic [7:0]       r_shift;
  logic             r_launch;
  logic             r_tx;
`ifdef DIGTAL_TX_PARITY_EN
  logic             r_par;
`endif

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_bit_end;
  logic             w_frame_done;
  logic [7:0]       w_rd_data;

  assign w_empty      = (r_level == '0);
  assign Tx_Ready     = (r_level != LVL_W'(FIFO_Depth));
  assign w_push       = Tx_Valid && Tx_Ready;
  // r_launch holds the counter for the one cycle between the IDLE pop and the start edge
  assign w_bit_end    = !r_launch && (r_cnt == CNT_LAST);
  assign w_frame_done = w_bit_end &&
                        (((r_state == S_STOP) && (Idle_Gap == 0)) ||
                         ((r_state == S_GAP) && (r_gap == GAP_LAST)));
  assign w_pop        = !w_empty && ((r_state == S_IDLE) || w_frame_done);
  assign w_rd_data    = r_mem[r_rd_ptr];

  assign Tx         = r_tx;
  assign Busy       = (r_state != S_IDLE) || !w_empty;
  assign FIFO_Level = r_level;

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= Tx_Data;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_gap    <= '0;
      r_shift  <= '0;
      r_launch <= 1'b0;
      r_tx     <= 1'b1;
`ifdef DIGTAL_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift  <= w_rd_data;
`ifdef DIGTAL_TX_PARITY_EN
            r_par    <= ^w_rd_data;
`endif
            r_launch <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (r_launch) begin
            r_launch <= 1'b0;
            r_tx     <= 1'b0;
          end else if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
`ifdef DIGTAL_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef DIGTAL_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (Idle_Gap > 0) begin
              r_gap   <= '0;
              r_state <= S_GAP;
            end else if (w_pop) begin
              // back-to-back: start bit begins on the same edge the stop bit ends
              r_shift <= w_rd_data;
`ifdef DIGTAL_TX_PARITY_EN
              r_par   <= ^w_rd_data;
`endif
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_gap == GAP_LAST) begin
              if (w_pop) begin
                r_shift <= w_rd_data;
`ifdef DIGTAL_TX_PARITY_EN
                r_par   <= ^w_rd_data;
`endif
                r_tx    <= 1'b0;
                r_state <= S_START;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_gap <= r_gap + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digtal_tx_frame.sv
// Scoreboard bench for digtal_tx_frame: a line monitor decodes frames and each test task
// compares the decoded stream and line timing against bench-side expectations.
module tb_digtal_tx_frame;

  localparam int BC = 32;
`ifdef DIGTAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME  = NB * BC;
  localparam int GFRAME = (NB + 2) * BC;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [7:0] Tx_Data;
  logic       Tx_Valid;
  logic       Tx_Ready;
  logic       Tx;
  logic       Busy;
  logic [4:0] FIFO_Level;

  logic [7:0] g_data;
  logic       g_valid;
  logic       g_ready;
  logic       g_tx;
  logic       g_busy;
  logic [4:0] g_level;

  int n_checks = 0;
  int n_fail   = 0;

  digtal_tx_frame u_dut (
    .Clock(Clock), .Reset_n(Reset_n), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid),
    .Tx_Ready(Tx_Ready), .Tx(Tx), .Busy(Busy), .FIFO_Level(FIFO_Level)
  );

  digtal_tx_frame #(.Idle_Gap(2)) u_gap (
    .Clock(Clock), .Reset_n(Reset_n), .Tx_Data(g_data), .Tx_Valid(g_valid),
    .Tx_Ready(g_ready), .Tx(g_tx), .Busy(g_busy), .FIFO_Level(g_level)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       frame_ok;
  } rx_t;

  rx_t        rx_q[$];
  int         start_q[$];
  logic [7:0] exp_q[$];

  // Line monitor: mid-bit sampling on the falling clock edge.
  int          ncyc = 0;
  int          m_cnt = 0;
  bit          m_act = 1'b0;
  logic        m_prev = 1'b1;
  logic [10:0] m_bits = '1;
  rx_t         m_rec;

  always @(negedge Clock) begin
    ncyc++;
    if (Reset_n !== 1'b1) begin
      m_act  = 1'b0;
      m_prev = 1'b1;
    end else begin
      if (!m_act) begin
        if (m_prev === 1'b1 && Tx === 1'b0) begin
          m_act = 1'b1;
          m_cnt = 0;
          start_q.push_back(ncyc);
        end
      end else begin
        m_cnt++;
      end
      if (m_act && (m_cnt % BC) == BC / 2) begin
        m_bits[m_cnt / BC] = Tx;
        if (m_cnt / BC == NB - 1) begin
          m_rec.data     = m_bits[8:1];
          m_rec.par      = m_bits[9];
          m_rec.frame_ok = (m_bits[0] === 1'b0) && (Tx === 1'b1);
          rx_q.push_back(m_rec);
          m_act = 1'b0;
        end
      end
      m_prev = Tx;
    end
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef DIGTAL_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i = 0;
    while ((Busy === 1'b1 || m_act) && i < budget) begin
      step();
      i++;
    end
    n_checks++;
    if (Busy !== 1'b0 || m_act) begin
      n_fail++;
      $display("FAIL %s_drain: busy=%b after %0d cycles, expected 0", name, Busy, budget);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Tx_Valid = 1'b0; Tx_Data = 8'h00; g_valid = 1'b0; g_data = 8'h00;
    repeat (3) step();
    n_checks++; if (Tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", Tx); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    n_checks++; if (FIFO_Level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", FIFO_Level); end
    n_checks++; if (Tx_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", Tx_Ready); end
    Reset_n = 1'b1;
    repeat (4) step();
    n_checks++; if (Tx !== 1'b1 || Busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: tx=%b busy=%b expected 1/0", Tx, Busy); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [10:0] fb;
    int bad, busy_bad;
    rx_t r;
    rx_q.delete(); start_q.delete(); exp_q.delete();
    fb = frame_bits(8'hEB);
    Tx_Data = 8'hEB; Tx_Valid = 1'b1; exp_q.push_back(8'hEB);
    step();
    Tx_Valid = 1'b0;
    n_checks++; if (FIFO_Level !== 5'd1) begin n_fail++; $display("FAIL single_level_push: got %0d expected 1", FIFO_Level); end
    step();
    n_checks++; if (FIFO_Level !== 5'd0) begin n_fail++; $display("FAIL single_level_pop: got %0d expected 0", FIFO_Level); end
    n_checks++; if (Tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_pre_start: got %b expected 1", Tx); end
    step();
    busy_bad = 0;
    for (int b = 0; b < NB; b++) begin
      bad = 0;
      for (int c = 0; c < BC; c++) begin
        if (Tx !== fb[b]) bad++;
        if (Busy !== 1'b1) busy_bad++;
        step();
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL single_bit%0d: %0d cycles off, expected level %b", b, bad, fb[b]); end
    end
    n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL single_busy_held: %0d low cycles, expected 0", busy_bad); end
    n_checks++; if (Busy !== 1'b0 || Tx !== 1'b1) begin n_fail++; $display("FAIL single_end: busy=%b tx=%b expected 0/1", Busy, Tx); end
    n_checks++;
    if (rx_q.size() != 1) begin
      n_fail++; $display("FAIL single_rx_count: got %0d expected 1", rx_q.size());
    end else begin
      r = rx_q.pop_front();
      if (r.data !== exp_q[0] || !r.frame_ok) begin
        n_fail++; $display("FAIL single_rx_data: got %h ok=%b expected %h", r.data, r.frame_ok, exp_q[0]);
      end
    end
    $display("test_single done: sent EB");
  endtask

  task automatic test_fill();
    logic [7:0] e;
    rx_t r;
    rx_q.delete(); start_q.delete(); exp_q.delete();
    Tx_Valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      Tx_Data = 8'(i);
      n_checks++;
      if (Tx_Ready !== 1'(i < 17)) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b expected %b", i, Tx_Ready, 1'(i < 17)); end
      if (i < 17) exp_q.push_back(8'(i));
      step();
    end
    Tx_Valid = 1'b0;
    n_checks++; if (FIFO_Level !== 5'd16) begin n_fail++; $display("FAIL fill_level_full: got %0d expected 16", FIFO_Level); end
    n_checks++; if (Tx_Ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_full: got %b expected 0", Tx_Ready); end
    repeat (FRAME + 1 - 19) step();
    n_checks++; if (Tx_Ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_before_pop: got %b expected 0", Tx_Ready); end
    step();
    n_checks++; if (Tx_Ready !== 1'b1 || FIFO_Level !== 5'd15) begin n_fail++; $display("FAIL fill_ready_after_pop: ready=%b level=%0d expected 1/15", Tx_Ready, FIFO_Level); end
    wait_drain(17 * FRAME + 200, "fill");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rx_q.size() == 0) begin
        n_fail++; $display("FAIL fill_rx_missing: got none expected %h", e);
      end else begin
        r = rx_q.pop_front();
        if (r.data !== e || !r.frame_ok) begin n_fail++; $display("FAIL fill_rx: got %h ok=%b expected %h", r.data, r.frame_ok, e); end
      end
    end
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL fill_rx_extra: got %0d extra expected 0", rx_q.size()); end
    n_checks++; if (start_q.size() != 17) begin n_fail++; $display("FAIL fill_starts: got %0d expected 17", start_q.size()); end
    for (int k = 1; k < start_q.size(); k++) begin
      n_checks++;
      if (start_q[k] - start_q[k-1] != FRAME) begin
        n_fail++; $display("FAIL fill_spacing[%0d]: got %0d expected %0d", k, start_q[k] - start_q[k-1], FRAME);
      end
    end
    $display("test_fill done: 17 bytes back-to-back");
  endtask

  task automatic test_gap();
    int hi_bad = 0;
    int i = 0;
    g_data = 8'h90; g_valid = 1'b1;
    step();
    step();
    g_valid = 1'b0;
    step();
    n_checks++; if (g_tx !== 1'b0) begin n_fail++; $display("FAIL gap_first_start: got %b expected 0", g_tx); end
    for (int j = 1; j <= GFRAME; j++) begin
      step();
      if (j >= FRAME - BC && j < GFRAME && g_tx !== 1'b1) hi_bad++;
    end
    n_checks++; if (hi_bad != 0) begin n_fail++; $display("FAIL gap_idle_high: %0d low cycles expected 0", hi_bad); end
    n_checks++; if (g_tx !== 1'b0) begin n_fail++; $display("FAIL gap_second_start: got %b expected 0 at +%0d", g_tx, GFRAME); end
    while (g_busy === 1'b1 && i < 2 * GFRAME) begin step(); i++; end
    n_checks++; if (g_busy !== 1'b0) begin n_fail++; $display("FAIL gap_drain: busy=%b expected 0", g_busy); end
    $display("test_gap done: spacing %0d", GFRAME);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    logic [7:0] e;
    rx_t r;
    rx_q.delete(); start_q.delete(); exp_q.delete();
    Tx_Valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Tx_Data = (i == 0) ? 8'h55 : 8'(8'hA0 + i);
      step();
    end
    Tx_Valid = 1'b0;
    n_checks++; if (FIFO_Level !== 5'd5) begin n_fail++; $display("FAIL rstmid_level: got %0d expected 5", FIFO_Level); end
    repeat (135) step();
    n_checks++; if (Tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_d3: got %b expected 0", Tx); end
    Reset_n = 1'b0;
    #1;
    n_checks++; if (Tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b expected 1", Tx); end
    n_checks++; if (FIFO_Level !== 5'd0) begin n_fail++; $display("FAIL rstmid_level0: got %0d expected 0", FIFO_Level); end
    n_checks++; if (Busy !== 1'b0 || Tx_Ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_flags: busy=%b ready=%b expected 0/1", Busy, Tx_Ready); end
    step();
    step();
    Reset_n = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (Tx !== 1'b1 || Busy !== 1'b0) bad++;
      step();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d active cycles expected 0", bad); end
    Tx_Data = 8'h3C; Tx_Valid = 1'b1; exp_q.push_back(8'h3C);
    step();
    Tx_Valid = 1'b0;
    wait_drain(2 * FRAME, "rstmid");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rx_q.size() == 0) begin
        n_fail++; $display("FAIL rstmid_rx_missing: got none expected %h", e);
      end else begin
        r = rx_q.pop_front();
        if (r.data !== e || !r.frame_ok) begin n_fail++; $display("FAIL rstmid_rx: got %h ok=%b expected %h", r.data, r.frame_ok, e); end
      end
    end
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL rstmid_rx_extra: got %0d extra expected 0", rx_q.size()); end
    $display("test_reset_mid done");
  endtask

  task automatic test_coincide();
    logic [7:0] d, e;
    rx_t r;
    rx_q.delete(); start_q.delete(); exp_q.delete();
    Tx_Valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom_range(0, 255));
      Tx_Data = d; exp_q.push_back(d);
      step();
    end
    Tx_Valid = 1'b0;
    n_checks++; if (FIFO_Level !== 5'd8) begin n_fail++; $display("FAIL coin_level_fill: got %0d expected 8", FIFO_Level); end
    repeat (FRAME + 1 - 8) step();
    n_checks++; if (FIFO_Level !== 5'd8) begin n_fail++; $display("FAIL coin_level_before: got %0d expected 8", FIFO_Level); end
    d = 8'($urandom_range(0, 255));
    Tx_Data = d; exp_q.push_back(d); Tx_Valid = 1'b1;
    step();
    Tx_Valid = 1'b0;
    n_checks++; if (FIFO_Level !== 5'd8) begin n_fail++; $display("FAIL coin_level_after: got %0d expected 8", FIFO_Level); end
    wait_drain(11 * FRAME + 200, "coin");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rx_q.size() == 0) begin
        n_fail++; $display("FAIL coin_rx_missing: got none expected %h", e);
      end else begin
        r = rx_q.pop_front();
        if (r.data !== e || !r.frame_ok) begin n_fail++; $display("FAIL coin_rx: got %h ok=%b expected %h", r.data, r.frame_ok, e); end
      end
    end
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL coin_rx_extra: got %0d extra expected 0", rx_q.size()); end
    $display("test_coincide done: 10 bytes");
  endtask

`ifdef DIGTAL_TX_PARITY_EN
  task automatic test_parity();
    rx_t r0, r1;
    rx_q.delete(); start_q.delete(); exp_q.delete();
    Tx_Valid = 1'b1;
    Tx_Data = 8'h01; step();
    Tx_Data = 8'hEB; step();
    Tx_Valid = 1'b0;
    wait_drain(3 * FRAME, "parity");
    n_checks++;
    if (rx_q.size() != 2) begin
      n_fail++; $display("FAIL parity_rx_count: got %0d expected 2", rx_q.size());
    end else begin
      r0 = rx_q.pop_front();
      r1 = rx_q.pop_front();
      n_checks++; if (r0.data !== 8'h01 || r0.par !== 1'b1) begin n_fail++; $display("FAIL parity_01: got %h/%b expected 01/1", r0.data, r0.par); end
      n_checks++; if (r1.data !== 8'hEB || r1.par !== 1'b0) begin n_fail++; $display("FAIL parity_EB: got %h/%b expected EB/0", r1.data, r1.par); end
    end
    n_checks++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != FRAME) begin
      n_fail++; $display("FAIL parity_frame_len: got %0d starts expected 2 spaced %0d", start_q.size(), FRAME);
    end
    $display("test_parity done");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_gap();
    test_reset_mid();
    test_coincide();
`ifdef DIGTAL_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
